// File: rtl/sram_write_buffer.sv
// sram_write_buffer: posted-write FIFO and port sequencer for a 1Mx16 async SRAM.
// Cache writes are buffered and drained in the background. Cache read misses
// are ordered against the buffered writes, so a read never returns stale data.
// Optional feature macro WB_FORWARD_EN: a read that hits a buffered entry is
// answered from the buffer, and a read miss runs ahead of draining.
//
// Ports:
//   Clk, Reset          clock; asynchronous active-high reset
//   wr_valid/ready      cache write handshake; wr_addr, wr_data are the payload
//   rd_valid, rd_addr   read request, held stable until rd_done
//   rd_done, rd_data    one-cycle completion pulse; rd_data holds the result
//   sram_*              SRAM address, active-low strobes, write data, read data
//   count, full, empty  FIFO occupancy
module sram_write_buffer #(
    parameter int DEPTH     = 4,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic                       wr_valid,
    output logic                       wr_ready,
    input  logic [15:0]                wr_addr,
    input  logic [15:0]                wr_data,
    input  logic                       rd_valid,
    input  logic [15:0]                rd_addr,
    output logic                       rd_done,
    output logic [15:0]                rd_data,
    output logic [19:0]                sram_addr,
    output logic                       sram_ce_n,
    output logic                       sram_oe_n,
    output logic                       sram_we_n,
    output logic [15:0]                sram_dout,
    input  logic [15:0]                sram_din,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, FWD} state_t;

    state_t        state_q, state_d;
    logic [7:0]    cyc_q, cyc_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [15:0]   fa_q [DEPTH];
    logic [15:0]   fa_d [DEPTH];
    logic [15:0]   fd_q [DEPTH];
    logic [15:0]   fd_d [DEPTH];
    logic [19:0]   addr_q, addr_d;
    logic [15:0]   dout_q, dout_d;
    logic [15:0]   rdata_q, rdata_d;
    logic          ce_n_q, ce_n_d;
    logic          oe_n_q, oe_n_d;
    logic          we_n_q, we_n_d;
    logic          done_q, done_d;
    logic          enq, deq, go_wr, go_rd;

    assign full      = (count_q == CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign wr_ready  = ~full;
    assign count     = count_q;
    assign rd_done   = done_q;
    assign rd_data   = rdata_q;
    assign sram_addr = addr_q;
    assign sram_dout = dout_q;
    assign sram_ce_n = ce_n_q;
    assign sram_oe_n = oe_n_q;
    assign sram_we_n = we_n_q;

`ifdef WB_FORWARD_EN
    // Oldest-to-youngest scan of registered entries; the last hit wins, so
    // the youngest matching write supplies the data.
    logic          fwd_hit;
    logic [15:0]   fwd_data;
    logic [PW-1:0] idx;

    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head_q + PW'(i);
            if (CW'(i) < count_q && fa_q[idx] == rd_addr) begin
                fwd_hit  = 1'b1;
                fwd_data = fd_q[idx];
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        fa_d    = fa_q;
        fd_d    = fd_q;
        addr_d  = addr_q;
        dout_d  = dout_q;
        rdata_d = rdata_q;
        ce_n_d  = ce_n_q;
        oe_n_d  = oe_n_q;
        we_n_d  = we_n_q;
        done_d  = 1'b0;
        go_wr   = 1'b0;
        go_rd   = 1'b0;
        deq     = 1'b0;
        enq     = wr_valid & ~full;

        // done_q marks the rd_done cycle; the request is still up then
        // and must not start a second access.
        unique case (state_q)
            IDLE: begin
`ifdef WB_FORWARD_EN
                if (rd_valid && !done_q) begin
                    if (fwd_hit) begin
                        state_d = FWD;
                        rdata_d = fwd_data;
                        done_d  = 1'b1;
                    end else begin
                        go_rd = 1'b1;
                    end
                end else if (!empty) begin
                    go_wr = 1'b1;
                end
`else
                if (!empty) begin
                    go_wr = 1'b1;
                end else if (rd_valid && !done_q) begin
                    go_rd = 1'b1;
                end
`endif
            end
            WRITE: begin
                if (cyc_q == 8'(WR_CYCLES - 1)) begin
                    we_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    deq     = 1'b1;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            READ: begin
                if (cyc_q == 8'(RD_CYCLES - 1)) begin
                    rdata_d = sram_din;
                    done_d  = 1'b1;
                    oe_n_d  = 1'b1;
                    ce_n_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            FWD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (go_wr) begin
            state_d = WRITE;
            cyc_d   = '0;
            addr_d  = {4'b0, fa_q[head_q]};
            dout_d  = fd_q[head_q];
            we_n_d  = 1'b0;
            ce_n_d  = 1'b0;
        end
        if (go_rd) begin
            state_d = READ;
            cyc_d   = '0;
            addr_d  = {4'b0, rd_addr};
            oe_n_d  = 1'b0;
            ce_n_d  = 1'b0;
        end

        if (enq) begin
            fa_d[tail_q] = wr_addr;
            fd_d[tail_q] = wr_data;
            tail_d       = tail_q + PW'(1);
        end
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        count_d = count_q + CW'(enq) - CW'(deq);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fa_q[i] <= '0;
                fd_q[i] <= '0;
            end
            addr_q  <= '0;
            dout_q  <= '0;
            rdata_q <= '0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            fa_q    <= fa_d;
            fd_q    <= fd_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
            rdata_q <= rdata_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            done_q  <= done_d;
        end
    end
endmodule

// File: tb/tb_sram_write_buffer.sv
// tb_sram_write_buffer: directed bench for sram_write_buffer with an SRAM model.
// Ports of the DUT are all driven/observed here; outputs are sampled at negedge.
module tb_sram_write_buffer;
    logic        Clk = 1'b0;
    logic        Reset;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic [15:0] rd_addr;
    logic        rd_done;
    logic [15:0] rd_data;
    logic [19:0] sram_addr;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [15:0] sram_dout;
    logic [15:0] sram_din;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int vectors     = 0;
    int miscompares = 0;

    sram_write_buffer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_addr   (rd_addr),
        .rd_done   (rd_done),
        .rd_data   (rd_data),
        .sram_addr (sram_addr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_dout (sram_dout),
        .sram_din  (sram_din),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    always #5 Clk = ~Clk;

    // SRAM model: a write lands when WE_n rises; reads are combinational.
    logic [15:0] sram_mem [0:65535];
    assign sram_din = sram_oe_n ? 16'h0000 : sram_mem[sram_addr[15:0]];

    int          we_run      = 0;
    int          oe_run      = 0;
    int          oe_count    = 0;
    int          last_oe_len = 0;
    int          overlap     = 0;
    int          busy_cycles = 0;
    logic [15:0] w_a;
    logic [15:0] w_d;
    logic [15:0] wl_addr [$];
    logic [15:0] wl_data [$];
    int          wl_len  [$];

    always @(posedge Clk) begin
        if (!sram_ce_n) busy_cycles++;
        if (!sram_we_n && !sram_oe_n) overlap++;
        if (!sram_we_n) begin
            we_run++;
            w_a = sram_addr[15:0];
            w_d = sram_dout;
        end else if (we_run > 0) begin
            wl_addr.push_back(w_a);
            wl_data.push_back(w_d);
            wl_len.push_back(we_run);
            sram_mem[w_a] = w_d;
            we_run = 0;
        end
        if (!sram_oe_n) begin
            oe_run++;
        end else if (oe_run > 0) begin
            last_oe_len = oe_run;
            oe_count++;
            oe_run = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] d);
        int n = 0;
        wr_valid = 1'b1;
        wr_addr  = a;
        wr_data  = d;
        while (!wr_ready && n < 50) begin
            @(negedge Clk);
            n++;
        end
        check("push_ready", 32'(wr_ready), 1);
        @(negedge Clk);
    endtask

    task automatic wait_done(output int lat);
        int n = 0;
        while (!rd_done && n < 40) begin
            @(negedge Clk);
            n++;
        end
        check("rd_done_seen", 32'(rd_done), 1);
        lat = n;
    endtask

    task automatic drain();
        int n = 0;
        while (!(empty && sram_ce_n && !rd_done) && n < 100) begin
            @(negedge Clk);
            n++;
        end
        check("drain_done", 32'(empty), 1);
        repeat (2) @(negedge Clk);
    endtask

    task automatic clear_log();
        wl_addr.delete();
        wl_data.delete();
        wl_len.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int o0;
        int b0;
        logic [15:0] ea [5];
        logic [15:0] ed [5];

        Reset    = 1'b1;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_valid = 1'b0;
        rd_addr  = '0;
        for (int i = 0; i < 65536; i++) sram_mem[i] = 16'h0000;
        sram_mem[16'h0020] = 16'h1234;
        sram_mem[16'h0200] = 16'h0BEE;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);

        // reset state
        check("rst_we_n", 32'(sram_we_n), 1);
        check("rst_oe_n", 32'(sram_oe_n), 1);
        check("rst_ce_n", 32'(sram_ce_n), 1);
        check("rst_addr", 32'(sram_addr), 0);
        check("rst_dout", 32'(sram_dout), 0);
        check("rst_rdata", 32'(rd_data), 0);
        check("rst_rdone", 32'(rd_done), 0);
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_ready", 32'(wr_ready), 1);

        // 1: three back-to-back writes
        clear_log();
        push(16'h0010, 16'hAAAA);
        push(16'h0011, 16'hBBBB);
        push(16'h0012, 16'hCCCC);
        wr_valid = 1'b0;
        check("t1_count3", 32'(count), 3);
        check("t1_we_low", 32'(sram_we_n), 0);
        check("t1_addr", 32'(sram_addr), 32'h10);
        drain();
        check("t1_nwrites", 32'(wl_addr.size()), 3);
        ea[0] = 16'h0010; ea[1] = 16'h0011; ea[2] = 16'h0012;
        ed[0] = 16'hAAAA; ed[1] = 16'hBBBB; ed[2] = 16'hCCCC;
        for (int i = 0; i < 3; i++) begin
            check("t1_waddr", 32'(wl_addr[i]), 32'(ea[i]));
            check("t1_wdata", 32'(wl_data[i]), 32'(ed[i]));
            check("t1_wlen", 32'(wl_len[i]), 2);
        end
        check("t1_empty", 32'(empty), 1);

        // 2: five writes while a read holds the port; buffer fills
        clear_log();
        o0 = oe_count;
        rd_valid = 1'b1;
        rd_addr  = 16'h0200;
        push(16'h0100, 16'h00D0);
        push(16'h0101, 16'h00D1);
        push(16'h0102, 16'h00D2);
        check("t2_rd_done", 32'(rd_done), 1);
        check("t2_rd_data", 32'(rd_data), 32'h0BEE);
        rd_valid = 1'b0;
        push(16'h0103, 16'h00D3);
        check("t2_count4", 32'(count), 4);
        check("t2_full", 32'(full), 1);
        check("t2_ready_low", 32'(wr_ready), 0);
        push(16'h0104, 16'h00D4);
        wr_valid = 1'b0;
        check("t2_count_after", 32'(count), 4);
        drain();
        check("t2_nwrites", 32'(wl_addr.size()), 5);
        for (int i = 0; i < 5; i++) begin
            check("t2_waddr", 32'(wl_addr[i]), 32'h100 + 32'(i));
            check("t2_wdata", 32'(wl_data[i]), 32'hD0 + 32'(i));
        end
        check("t2_reads", oe_count - o0, 1);

        // 3: plain read from an empty buffer
        o0 = oe_count;
        rd_valid = 1'b1;
        rd_addr  = 16'h0020;
        wait_done(lat);
        check("t3_latency", 32'(lat), 3);
        check("t3_rd_data", 32'(rd_data), 32'h1234);
        @(negedge Clk);
        rd_valid = 1'b0;
        check("t3_pulse", 32'(rd_done), 0);
        check("t3_hold", 32'(rd_data), 32'h1234);
        check("t3_oe_len", 32'(last_oe_len), 2);
        repeat (3) @(negedge Clk);
        check("t3_single_read", oe_count - o0, 1);

        // 4: read right after a write to the same address
        clear_log();
        o0 = oe_count;
        push(16'h0030, 16'h5555);
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 16'h0030;
        wait_done(lat);
        check("t4_rd_data", 32'(rd_data), 32'h5555);
        rd_valid = 1'b0;
        @(negedge Clk);
`ifdef WB_FORWARD_EN
        check("t4_latency", 32'(lat), 1);
        check("t4_no_oe", oe_count - o0, 0);
`else
        check("t4_latency", 32'(lat), 6);
        check("t4_one_read", oe_count - o0, 1);
        check("t4_write_first", 32'(wl_addr.size()), 1);
`endif
        drain();

        // 5: two writes to one address, read returns the younger
        push(16'h0060, 16'h6666);
        push(16'h0040, 16'h1111);
        push(16'h0040, 16'h2222);
        wr_valid = 1'b0;
        rd_valid = 1'b1;
        rd_addr  = 16'h0040;
        wait_done(lat);
        check("t5_rd_data", 32'(rd_data), 32'h2222);
`ifdef WB_FORWARD_EN
        check("t5_latency", 32'(lat), 2);
`else
        check("t5_latency", 32'(lat), 10);
`endif
        rd_valid = 1'b0;
        drain();

        // 6: reset in the middle of a write with three entries
        push(16'h0070, 16'h7770);
        push(16'h0071, 16'h7771);
        push(16'h0072, 16'h7772);
        wr_valid = 1'b0;
        check("t6_pre_we", 32'(sram_we_n), 0);
        check("t6_pre_count", 32'(count), 3);
        Reset = 1'b1;
        #1;
        check("t6_we_n", 32'(sram_we_n), 1);
        check("t6_ce_n", 32'(sram_ce_n), 1);
        check("t6_count", 32'(count), 0);
        check("t6_empty", 32'(empty), 1);
        @(negedge Clk);
        Reset = 1'b0;
        clear_log();
        b0 = busy_cycles;
        repeat (10) @(negedge Clk);
        check("t6_no_access", busy_cycles - b0, 0);
        check("t6_no_writes", 32'(wl_addr.size()), 0);
        check("t6_count_after", 32'(count), 0);

        check("we_oe_overlap", 32'(overlap), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
